// File: rtl/ram_single_port_pkg.sv
// Shared sizing for the single-port RAM: default word width, address width and derived depth.
package ram_single_port_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 11;

  // Word count for a given address width; every address value is a valid word.
  function automatic int depth_of(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

  localparam int RAM_DEPTH = depth_of(RAM_ADDR_WIDTH);

endpackage

// File: rtl/ram_single_port.sv
// Single-port synchronous RAM with a registered address; read data is the array
// indexed by that registered address, giving write-first behaviour and block-RAM inference.
module ram_single_port
  import ram_single_port_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_out
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_r;

  // Array write port; contents are never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_r[addr_in] <= data_in;
    end
  end

  // Registered access address; only this register sees the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      addr_r <= addr_in;
    end
  end

  assign addr_out = addr_r;
  assign data_out = mem_r[addr_r];

endmodule

// File: tb/tb_ram_single_port.sv
// Directed self-checking bench for ram_single_port: fill, readback, write disable,
// asynchronous reset mid-operation, back-to-back mixes and address extremes.
module tb_ram_single_port;

  logic        clk;
  logic        rst;
  logic        we;
  logic [7:0]  data_in;
  logic [10:0] addr_in;
  logic [7:0]  data_out;
  logic [10:0] addr_out;

  int checks;
  int errors;

  ram_single_port dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .data_in  (data_in),
    .addr_in  (addr_in),
    .data_out (data_out),
    .addr_out (addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: drive inputs, take the edge, then look 1 time unit later.
  task automatic access(input logic w, input logic [10:0] a, input logic [7:0] d);
    we      = w;
    addr_in = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    we      = 1'b0;
    addr_in = 11'h155;
    data_in = 8'h00;
    #1;
    check("reset_addr", 32'(addr_out), 32'd0);
    @(posedge clk);
    #1;
    check("reset_addr_clocked", 32'(addr_out), 32'd0);
    rst = 1'b0;

    // Sequential fill: address i gets i+1, visible one cycle later.
    for (int i = 0; i <= 10; i++) begin
      access(1'b1, 11'(i), 8'(i + 1));
      check($sformatf("fill_addr_%0d", i), 32'(addr_out), 32'(i));
      check($sformatf("fill_data_%0d", i), 32'(data_out), 32'(i + 1));
    end

    // Readback with writes disabled.
    for (int i = 0; i <= 10; i++) begin
      access(1'b0, 11'(i), 8'hFF);
      check($sformatf("read_addr_%0d", i), 32'(addr_out), 32'(i));
      check($sformatf("read_data_%0d", i), 32'(data_out), 32'(i + 1));
    end

    // Write disable: data_in must not reach the array.
    access(1'b0, 11'd3, 8'hFF);
    check("wdis_data", 32'(data_out), 32'h04);
    access(1'b0, 11'd7, 8'hFF);
    check("wdis_other", 32'(data_out), 32'h08);
    access(1'b0, 11'd3, 8'h00);
    check("wdis_reread", 32'(data_out), 32'h04);

    // Asynchronous reset between edges while addr_out = 10.
    access(1'b0, 11'd10, 8'h00);
    check("pre_rst_addr", 32'(addr_out), 32'd10);
    check("pre_rst_data", 32'(data_out), 32'h0B);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_addr", 32'(addr_out), 32'd0);
    check("async_rst_data", 32'(data_out), 32'h01);
    access(1'b1, 11'd5, 8'hEE);
    check("rst_write_addr", 32'(addr_out), 32'd0);
    check("rst_write_data0", 32'(data_out), 32'h01);
    access(1'b1, 11'd0, 8'hEE);
    check("rst_write_mem0", 32'(data_out), 32'h01);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      access(1'b0, 11'(i), 8'h00);
      check($sformatf("post_rst_data_%0d", i), 32'(data_out), 32'(i + 1));
    end
    access(1'b0, 11'd0, 8'h00);
    check("post_rst_data_0", 32'(data_out), 32'h01);

    // Back-to-back mixed writes and reads of different addresses.
    access(1'b1, 11'd20, 8'h33);
    check("b2b_w20", 32'(data_out), 32'h33);
    access(1'b0, 11'd4, 8'h99);
    check("b2b_r4_addr", 32'(addr_out), 32'd4);
    check("b2b_r4", 32'(data_out), 32'h05);
    access(1'b1, 11'd21, 8'h44);
    check("b2b_w21", 32'(data_out), 32'h44);
    access(1'b0, 11'd20, 8'h00);
    check("b2b_r20", 32'(data_out), 32'h33);
    access(1'b0, 11'd21, 8'h00);
    check("b2b_r21", 32'(data_out), 32'h44);

    // Address extremes, checking no aliasing between top and bottom words.
    access(1'b1, 11'h7FF, 8'hA5);
    check("ext_w7ff_addr", 32'(addr_out), 32'h7FF);
    check("ext_w7ff", 32'(data_out), 32'hA5);
    access(1'b1, 11'h000, 8'h5A);
    check("ext_w000", 32'(data_out), 32'h5A);
    access(1'b0, 11'h7FF, 8'h00);
    check("ext_r7ff", 32'(data_out), 32'hA5);
    access(1'b0, 11'h000, 8'h00);
    check("ext_r000", 32'(data_out), 32'h5A);
    access(1'b0, 11'h3FF, 8'h00);
    check("ext_r3ff_addr", 32'(addr_out), 32'h3FF);
    access(1'b0, 11'd10, 8'h00);
    check("ext_r10", 32'(data_out), 32'h0B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
